// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - AXI4-Stream style bundle used by the requesters and the shifter port
//
// Signals: tdata (WIDTH), tkeep (WIDTH/8), tlast, tvalid, tready.
// master drives tdata/tkeep/tlast/tvalid and samples tready; slave is the mirror.
interface shift_arbiter_if #(
    parameter int WIDTH = 512
);
    localparam int BYTES = WIDTH / 8;

    logic [WIDTH-1:0] tdata;
    logic [BYTES-1:0] tkeep;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - packet-locked round-robin arbiter feeding one barrel-shifter input
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   i_data[NUM_REQ]      requester streams (slave side)
//   o_data               registered stream to the shifter (master side)
//   o_offset             shift offset of the packet on o_data, constant per packet
//   o_grant              index of the locked requester
//   o_busy               high while a packet lock is held
//   i_cfg_we/sel/offset  offset table write port (clamped to BYTES)
// Optional (macro SHIFT_ARBITER_STATS_EN):
//   i_stat_sel           packet counter select
//   o_stat_count         registered saturating packet count of the selected requester
module shift_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 512,
    parameter int BYTES        = WIDTH / 8,
    parameter int OFFSET_WIDTH = $clog2(BYTES) + 1,
    parameter int REQ_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    shift_arbiter_if.slave          i_data [NUM_REQ],
    shift_arbiter_if.master         o_data,
    output logic [OFFSET_WIDTH-1:0] o_offset,
    output logic [REQ_WIDTH-1:0]    o_grant,
    output logic                    o_busy,
    input  logic                    i_cfg_we,
    input  logic [REQ_WIDTH-1:0]    i_cfg_sel,
    input  logic [OFFSET_WIDTH-1:0] i_cfg_offset
`ifdef SHIFT_ARBITER_STATS_EN
    ,
    input  logic [REQ_WIDTH-1:0]    i_stat_sel,
    output logic [31:0]             o_stat_count
`endif
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [REQ_WIDTH-1:0]    rr_q, rr_d;
    logic [REQ_WIDTH-1:0]    grant_q, grant_d;
    logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
    logic                    busy_q, busy_d;

    // Output slice
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [WIDTH-1:0]        tdata_q, tdata_d;
    logic [BYTES-1:0]        tkeep_q, tkeep_d;

    logic [OFFSET_WIDTH-1:0] table_q [NUM_REQ];
    logic [OFFSET_WIDTH-1:0] table_d [NUM_REQ];

    // Flattened requester signals so they can be indexed by the grant
    logic [NUM_REQ-1:0]      req_tvalid;
    logic [NUM_REQ-1:0]      req_tlast;
    logic [NUM_REQ-1:0]      req_tready;
    logic [WIDTH-1:0]        req_tdata [NUM_REQ];
    logic [BYTES-1:0]        req_tkeep [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req_tvalid[g]     = i_data[g].tvalid;
        assign req_tlast[g]      = i_data[g].tlast;
        assign req_tdata[g]      = i_data[g].tdata;
        assign req_tkeep[g]      = i_data[g].tkeep;
        assign i_data[g].tready  = req_tready[g];
    end

    logic                 slice_free;
    logic                 any_valid;
    logic [REQ_WIDTH-1:0] sel;
    logic [REQ_WIDTH-1:0] rr_wrap;

    // The slice can take a beat if it is empty or its current beat leaves this cycle.
    // The same condition gates a new grant, so o_offset/o_grant never change under a
    // final beat that is still waiting downstream.
    assign slice_free = !tvalid_q || o_data.tready;

    // First valid requester searching cyclically from the rr pointer
    always_comb begin
        logic [REQ_WIDTH-1:0] idx;
        any_valid = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = REQ_WIDTH'((int'(rr_q) + i) % NUM_REQ);
            if (!any_valid && req_tvalid[idx]) begin
                any_valid = 1'b1;
                sel       = idx;
            end
        end
    end

    always_comb begin
        rr_wrap = '0;
        if (int'(grant_q) != NUM_REQ - 1) begin
            rr_wrap = grant_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        offset_d   = offset_q;
        busy_d     = busy_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        req_tready = '0;

        if (tvalid_q && o_data.tready) begin
            tvalid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (any_valid && slice_free) begin
                state_d  = ST_LOCKED;
                grant_d  = sel;
                offset_d = table_q[sel];
                busy_d   = 1'b1;
            end
        end else begin
            req_tready[grant_q] = slice_free;
            if (req_tvalid[grant_q] && slice_free) begin
                // A load overrides the drain above: full throughput on simultaneous handshakes
                tvalid_d = 1'b1;
                tdata_d  = req_tdata[grant_q];
                tkeep_d  = req_tkeep[grant_q];
                tlast_d  = req_tlast[grant_q];
                if (req_tlast[grant_q]) begin
                    state_d = ST_IDLE;
                    rr_d    = rr_wrap;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            table_d[k] = table_q[k];
        end
        if (i_cfg_we && (int'(i_cfg_sel) < NUM_REQ)) begin
            if (int'(i_cfg_offset) > BYTES) begin
                table_d[i_cfg_sel] = OFFSET_WIDTH'(BYTES);
            end else begin
                table_d[i_cfg_sel] = i_cfg_offset;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            offset_q <= '0;
            busy_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                table_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            offset_q <= offset_d;
            busy_q   <= busy_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                table_q[k] <= table_d[k];
            end
        end
    end

    assign o_data.tvalid = tvalid_q;
    assign o_data.tdata  = tdata_q;
    assign o_data.tkeep  = tkeep_q;
    assign o_data.tlast  = tlast_q;
    assign o_offset      = offset_q;
    assign o_grant       = grant_q;
    assign o_busy        = busy_q;

`ifdef SHIFT_ARBITER_STATS_EN
    logic [31:0] cnt_q [NUM_REQ];
    logic [31:0] cnt_d [NUM_REQ];
    logic [31:0] stat_q, stat_d;
    logic        last_acc;

    // Counted when the tlast beat is taken from the requester
    assign last_acc = (state_q == ST_LOCKED) && req_tvalid[grant_q]
                      && req_tlast[grant_q] && slice_free;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (last_acc && (cnt_q[grant_q] != 32'hFFFF_FFFF)) begin
            cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
        end
        stat_d = '0;
        if (int'(i_stat_sel) < NUM_REQ) begin
            stat_d = cnt_q[i_stat_sel];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_q <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            stat_q <= stat_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_stat_count = stat_q;
`endif

endmodule
